dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/loader data-memory arbiter with round-robin, lock bursts and read tagging
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LOCK   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n_i,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  output logic                  cpu_stall_o,
  output logic                  cpu_rvalid_o,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  input  logic                  ldr_req_i,
  input  logic                  ldr_we_i,
  input  logic [ADDR_WIDTH-1:0] ldr_addr_i,
  input  logic [DATA_WIDTH-1:0] ldr_wdata_i,
  input  logic                  ldr_lock_i,
  output logic                  ldr_gnt_o,
  output logic                  ldr_rvalid_o,
  output logic [DATA_WIDTH-1:0] ldr_rdata_o,
  output logic                  mem_readmem_o,
  output logic                  mem_writemem_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic [DATA_WIDTH-1:0] mem_q_i
);

  typedef enum logic [1:0] {ARB, LDR_BURST, YIELD} state_t;

  state_t                state, stateNext;
  logic                  lastGnt;      // 1: loader was granted most recently
  logic [3:0]            lockCnt, lockCntNext;
  logic [3:0]            beatCnt;
  logic                  cpuGnt, ldrGnt, anyGnt, selWe;
  logic                  tagValid, tagOwner;  // owner 1: loader
  logic [DATA_WIDTH-1:0] cpuRdataQ, ldrRdataQ;

  always_comb begin
    cpuGnt      = 1'b0;
    ldrGnt      = 1'b0;
    stateNext   = state;
    lockCntNext = lockCnt;
    beatCnt     = 4'd0;
    if (rst_n_i) begin
      if (state == YIELD) begin
        cpuGnt      = cpu_req_i;
        stateNext   = ARB;
        lockCntNext = 4'd0;
      end else begin
        if (state == LDR_BURST && ldr_req_i && ldr_lock_i) begin
          ldrGnt = 1'b1;
        end else if (cpu_req_i && ldr_req_i) begin
          cpuGnt = lastGnt;
          ldrGnt = ~lastGnt;
        end else begin
          cpuGnt = cpu_req_i;
          ldrGnt = ldr_req_i;
        end
        // A locked loader beat opens or extends a burst; the entry beat counts.
        if (ldrGnt && ldr_lock_i) begin
          beatCnt = ((state == LDR_BURST) ? lockCnt : 4'd0) + 4'd1;
          if (beatCnt == 4'(MAX_LOCK)) begin
            lockCntNext = 4'd0;
            stateNext   = cpu_req_i ? YIELD : LDR_BURST;
          end else begin
            lockCntNext = beatCnt;
            stateNext   = LDR_BURST;
          end
        end else begin
          lockCntNext = 4'd0;
          stateNext   = ARB;
        end
      end
    end
  end

  assign anyGnt         = cpuGnt | ldrGnt;
  assign selWe          = cpuGnt ? cpu_we_i : ldr_we_i;
  assign cpu_stall_o    = cpu_req_i & ~cpuGnt;
  assign ldr_gnt_o      = ldrGnt;
  assign mem_writemem_o = anyGnt & selWe;
  assign mem_readmem_o  = anyGnt & ~selWe;
  assign mem_addr_o     = cpuGnt ? cpu_addr_i  : (ldrGnt ? ldr_addr_i  : '0);
  assign mem_data_o     = cpuGnt ? cpu_wdata_i : (ldrGnt ? ldr_wdata_i : '0);

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= ARB;
      lastGnt <= 1'b1;
      lockCnt <= 4'd0;
    end else begin
      state   <= stateNext;
      lockCnt <= lockCntNext;
      if (anyGnt) lastGnt <= ldrGnt;
    end
  end

  // Read data arrives one cycle after the grant; the tag routes it to its owner.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tagValid  <= 1'b0;
      tagOwner  <= 1'b0;
      cpuRdataQ <= '0;
      ldrRdataQ <= '0;
    end else begin
      tagValid <= mem_readmem_o;
      tagOwner <= ldrGnt;
      if (cpu_rvalid_o) cpuRdataQ <= mem_q_i;
      if (ldr_rvalid_o) ldrRdataQ <= mem_q_i;
    end
  end

  assign cpu_rvalid_o = tagValid & ~tagOwner;
  assign ldr_rvalid_o = tagValid & tagOwner;
  assign cpu_rdata_o  = cpu_rvalid_o ? mem_q_i : cpuRdataQ;
  assign ldr_rdata_o  = ldr_rvalid_o ? mem_q_i : ldrRdataQ;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed and randomized checks of dmem_arbiter against a behavioural model
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int ML = 4;

  logic          clk = 1'b0;
  logic          rst_n_i;
  logic          cpu_req_i, cpu_we_i, ldr_req_i, ldr_we_i, ldr_lock_i;
  logic [AW-1:0] cpu_addr_i, ldr_addr_i;
  logic [DW-1:0] cpu_wdata_i, ldr_wdata_i;
  logic          cpu_stall_o, cpu_rvalid_o, ldr_gnt_o, ldr_rvalid_o;
  logic [DW-1:0] cpu_rdata_o, ldr_rdata_o;
  logic          mem_readmem_o, mem_writemem_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o, mem_q_i;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] shadow [256];
  logic          fillMem = 1'b0;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst_n_i(rst_n_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_stall_o(cpu_stall_o), .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
    .ldr_req_i(ldr_req_i), .ldr_we_i(ldr_we_i), .ldr_addr_i(ldr_addr_i), .ldr_wdata_i(ldr_wdata_i),
    .ldr_lock_i(ldr_lock_i), .ldr_gnt_o(ldr_gnt_o), .ldr_rvalid_o(ldr_rvalid_o), .ldr_rdata_o(ldr_rdata_o),
    .mem_readmem_o(mem_readmem_o), .mem_writemem_o(mem_writemem_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_q_i(mem_q_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fillMem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 3 + 1);
    end else if (mem_writemem_o) begin
      mem[mem_addr_o] <= mem_data_o;
    end
    if (mem_readmem_o) mem_q_i <= mem[mem_addr_o];
  end

  task automatic idleInputs;
    cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_wdata_i = '0;
    ldr_req_i = 0; ldr_we_i = 0; ldr_addr_i = '0; ldr_wdata_i = '0; ldr_lock_i = 0;
  endtask

  task automatic applyReset;
    @(negedge clk);
    rst_n_i = 0;
    idleInputs();
    fillMem = 1;
    @(negedge clk);
    fillMem = 0;
    rst_n_i = 1;
    for (int i = 0; i < 256; i++) shadow[i] = 8'(i * 3 + 1);
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n_i = 0;
    cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 8'h12; cpu_wdata_i = 8'h34;
    ldr_req_i = 1; ldr_we_i = 1; ldr_addr_i = 8'h56; ldr_wdata_i = 8'h78; ldr_lock_i = 1;
    #1;
    checks++; if (cpu_stall_o !== 1'b1) begin failures++; $display("FAIL reset_stall got=%b exp=1", cpu_stall_o); end
    checks++; if (ldr_gnt_o !== 1'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", ldr_gnt_o); end
    checks++; if ({mem_readmem_o, mem_writemem_o} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b exp=00", {mem_readmem_o, mem_writemem_o}); end
    checks++; if ({mem_addr_o, mem_data_o} !== 16'h0) begin failures++; $display("FAIL reset_bus got=%h exp=0000", {mem_addr_o, mem_data_o}); end
    checks++; if ({cpu_rvalid_o, ldr_rvalid_o} !== 2'b00) begin failures++; $display("FAIL reset_rvalid got=%b exp=00", {cpu_rvalid_o, ldr_rvalid_o}); end
    checks++; if ({cpu_rdata_o, ldr_rdata_o} !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", {cpu_rdata_o, ldr_rdata_o}); end
  endtask

  task automatic test_tie_read;
    applyReset();
    @(negedge clk);
    cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 8'h10;
    ldr_req_i = 1; ldr_we_i = 0; ldr_addr_i = 8'h20;
    #1;
    checks++; if ({cpu_stall_o, ldr_gnt_o} !== 2'b00) begin failures++; $display("FAIL tie_first_cpu stall_gnt got=%b exp=00", {cpu_stall_o, ldr_gnt_o}); end
    checks++; if ({mem_readmem_o, mem_addr_o} !== {1'b1, 8'h10}) begin failures++; $display("FAIL tie_first_bus got=%b/%h exp=1/10", mem_readmem_o, mem_addr_o); end
    @(negedge clk);
    cpu_req_i = 0;
    #1;
    checks++; if ({ldr_gnt_o, mem_addr_o} !== {1'b1, 8'h20}) begin failures++; $display("FAIL tie_second_ldr got=%b/%h exp=1/20", ldr_gnt_o, mem_addr_o); end
    checks++; if ({cpu_rvalid_o, cpu_rdata_o} !== {1'b1, 8'h31}) begin failures++; $display("FAIL tie_cpu_resp got=%b/%h exp=1/31", cpu_rvalid_o, cpu_rdata_o); end
    @(negedge clk);
    ldr_req_i = 0;
    #1;
    checks++; if ({ldr_rvalid_o, ldr_rdata_o} !== {1'b1, 8'h61}) begin failures++; $display("FAIL tie_ldr_resp got=%b/%h exp=1/61", ldr_rvalid_o, ldr_rdata_o); end
    checks++; if ({cpu_rvalid_o, cpu_rdata_o} !== {1'b0, 8'h31}) begin failures++; $display("FAIL tie_cpu_hold got=%b/%h exp=0/31", cpu_rvalid_o, cpu_rdata_o); end
  endtask

  task automatic test_raw;
    @(negedge clk);
    ldr_req_i = 1; ldr_we_i = 1; ldr_addr_i = 8'h33; ldr_wdata_i = 8'hA5;
    #1;
    checks++; if ({mem_writemem_o, mem_readmem_o, mem_data_o} !== {2'b10, 8'hA5}) begin failures++; $display("FAIL raw_write got=%b%b/%h exp=10/a5", mem_writemem_o, mem_readmem_o, mem_data_o); end
    @(negedge clk);
    ldr_req_i = 0;
    cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 8'h33;
    #1;
    checks++; if ({cpu_stall_o, mem_readmem_o} !== 2'b01) begin failures++; $display("FAIL raw_read_grant got=%b exp=01", {cpu_stall_o, mem_readmem_o}); end
    @(negedge clk);
    cpu_req_i = 0;
    #1;
    checks++; if ({cpu_rvalid_o, cpu_rdata_o} !== {1'b1, 8'hA5}) begin failures++; $display("FAIL raw_resp got=%b/%h exp=1/a5", cpu_rvalid_o, cpu_rdata_o); end
  endtask

  task automatic test_lock_yield;
    logic [7:0] ldrPattern;
    ldrPattern = 8'b1101_1110;  // cycle k: 1 = loader wins, 0 = CPU wins
    applyReset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cpu_req_i = 1; cpu_we_i = 1; cpu_addr_i = 8'h40; cpu_wdata_i = 8'(k);
      ldr_req_i = 1; ldr_we_i = 1; ldr_addr_i = 8'(8'h80 + k); ldr_wdata_i = 8'(k + 8'h10); ldr_lock_i = 1;
      #1;
      checks++; if (ldr_gnt_o !== ldrPattern[k]) begin failures++; $display("FAIL lock_yield_gnt cycle=%0d got=%b exp=%b", k, ldr_gnt_o, ldrPattern[k]); end
      checks++; if (cpu_stall_o !== ldrPattern[k]) begin failures++; $display("FAIL lock_yield_stall cycle=%0d got=%b exp=%b", k, cpu_stall_o, ldrPattern[k]); end
    end
    @(negedge clk);
    idleInputs();
  endtask

  task automatic test_lock_idle;
    applyReset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      ldr_req_i = 1; ldr_we_i = 1; ldr_addr_i = 8'(k); ldr_wdata_i = 8'(k); ldr_lock_i = 1;
      #1;
      checks++; if ({ldr_gnt_o, cpu_stall_o} !== 2'b10) begin failures++; $display("FAIL lock_idle cycle=%0d gnt_stall got=%b exp=10", k, {ldr_gnt_o, cpu_stall_o}); end
    end
    @(negedge clk);
    idleInputs();
  endtask

  task automatic test_reset_inflight;
    applyReset();
    @(negedge clk);
    cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = 8'h05;
    #1;
    checks++; if ({cpu_stall_o, mem_readmem_o} !== 2'b01) begin failures++; $display("FAIL inflight_grant got=%b exp=01", {cpu_stall_o, mem_readmem_o}); end
    @(posedge clk);
    #1;
    rst_n_i = 0;
    cpu_req_i = 0;
    #1;
    checks++; if ({cpu_rvalid_o, ldr_rvalid_o, ldr_gnt_o, cpu_stall_o, mem_readmem_o, mem_writemem_o} !== 6'b0) begin failures++; $display("FAIL inflight_ctrl_in_reset got=%b exp=000000", {cpu_rvalid_o, ldr_rvalid_o, ldr_gnt_o, cpu_stall_o, mem_readmem_o, mem_writemem_o}); end
    checks++; if ({cpu_rdata_o, ldr_rdata_o, mem_addr_o, mem_data_o} !== 32'h0) begin failures++; $display("FAIL inflight_data_in_reset got=%h exp=0", {cpu_rdata_o, ldr_rdata_o, mem_addr_o, mem_data_o}); end
    @(negedge clk);
    rst_n_i = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (cpu_rvalid_o !== 1'b0) begin failures++; $display("FAIL inflight_no_rvalid cycle=%0d got=%b exp=0", k, cpu_rvalid_o); end
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    bit inBurst, yieldNext, lastWasLdr, expC, expL, expWr, expRd;
    bit pendValid, pendLdr;
    int burstBeats;
    logic [DW-1:0] pendData, lastCpuData, lastLdrData, expData;
    logic [AW-1:0] expAddr;
    applyReset();
    inBurst = 0; yieldNext = 0; lastWasLdr = 1; burstBeats = 0;
    pendValid = 0; pendLdr = 0; pendData = '0; lastCpuData = '0; lastLdrData = '0;
    expC = 0; expL = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (!cpu_req_i || expC) begin
        cpu_req_i = ($urandom_range(0, 2) != 0);
        cpu_we_i = $urandom_range(0, 1) == 1;
        cpu_addr_i = 8'($urandom_range(0, 7));
        cpu_wdata_i = 8'($urandom);
      end
      if (!ldr_req_i || expL) begin
        ldr_req_i = ($urandom_range(0, 3) != 0);
        ldr_we_i = $urandom_range(0, 1) == 1;
        ldr_addr_i = 8'($urandom_range(0, 7));
        ldr_wdata_i = 8'($urandom);
        ldr_lock_i = ($urandom_range(0, 3) != 0);
      end
      if (yieldNext) begin
        expC = cpu_req_i; expL = 0;
      end else if (inBurst && ldr_req_i && ldr_lock_i) begin
        expC = 0; expL = 1;
      end else if (cpu_req_i && ldr_req_i) begin
        expC = lastWasLdr; expL = !lastWasLdr;
      end else begin
        expC = cpu_req_i; expL = ldr_req_i;
      end
      expWr = (expC && cpu_we_i) || (expL && ldr_we_i);
      expRd = (expC && !cpu_we_i) || (expL && !ldr_we_i);
      expAddr = expC ? cpu_addr_i : (expL ? ldr_addr_i : '0);
      expData = expC ? cpu_wdata_i : (expL ? ldr_wdata_i : '0);
      #1;
      checks++; if ({cpu_stall_o, ldr_gnt_o} !== {cpu_req_i && !expC, expL}) begin failures++; $display("FAIL rand_grant cycle=%0d stall_gnt got=%b exp=%b", cyc, {cpu_stall_o, ldr_gnt_o}, {cpu_req_i && !expC, expL}); end
      checks++; if ({mem_readmem_o, mem_writemem_o, mem_addr_o, mem_data_o} !== {expRd, expWr, expAddr, expData}) begin failures++; $display("FAIL rand_bus cycle=%0d got=%b%b/%h/%h exp=%b%b/%h/%h", cyc, mem_readmem_o, mem_writemem_o, mem_addr_o, mem_data_o, expRd, expWr, expAddr, expData); end
      checks++; if ({cpu_rvalid_o, cpu_rdata_o} !== {pendValid && !pendLdr, (pendValid && !pendLdr) ? pendData : lastCpuData}) begin failures++; $display("FAIL rand_cpu_resp cycle=%0d got=%b/%h exp=%b/%h", cyc, cpu_rvalid_o, cpu_rdata_o, pendValid && !pendLdr, (pendValid && !pendLdr) ? pendData : lastCpuData); end
      checks++; if ({ldr_rvalid_o, ldr_rdata_o} !== {pendValid && pendLdr, (pendValid && pendLdr) ? pendData : lastLdrData}) begin failures++; $display("FAIL rand_ldr_resp cycle=%0d got=%b/%h exp=%b/%h", cyc, ldr_rvalid_o, ldr_rdata_o, pendValid && pendLdr, (pendValid && pendLdr) ? pendData : lastLdrData); end
      @(posedge clk);
      if (pendValid && !pendLdr) lastCpuData = pendData;
      if (pendValid && pendLdr) lastLdrData = pendData;
      pendValid = expRd; pendLdr = expL;
      if (expRd) pendData = shadow[expAddr];
      if (expWr) shadow[expAddr] = expData;
      if (expC || expL) lastWasLdr = expL;
      if (yieldNext) begin
        yieldNext = 0; inBurst = 0; burstBeats = 0;
      end else if (expL && ldr_lock_i) begin
        burstBeats = (inBurst ? burstBeats : 0) + 1;
        inBurst = 1;
        if (burstBeats == ML) begin
          burstBeats = 0;
          if (cpu_req_i) begin yieldNext = 1; inBurst = 0; end
        end
      end else begin
        inBurst = 0; burstBeats = 0;
      end
    end
    @(negedge clk);
    idleInputs();
  endtask

  initial begin
    rst_n_i = 0;
    idleInputs();
    test_reset();
    test_tie_read();
    test_raw();
    test_lock_yield();
    test_lock_idle();
    test_reset_inflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
